// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   mult_sequencer_state_e : controller states IDLE / CALC / DONE
//   DW_DEFAULT             : default operand width in bits
package mult_sequencer_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_sequencer_state_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: operand shift registers, 2*DW-bit
// accumulator, iteration counter and the registered product.
//   clk, rst      : clock, asynchronous active-high reset
//   load          : capture operands, clear accumulator and counter
//   step          : perform one shift-add iteration
//   store         : write the post-iteration accumulator into product
//   multiplicand  : operand A (DW bits)
//   multiplier    : operand B (DW bits)
//   product       : registered result (2*DW bits)
//   cnt_last      : counter holds DW-1 (final iteration this cycle)
module mult_datapath #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            store,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic [2*DW-1:0] product,
  output logic            cnt_last
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  logic [2*DW-1:0] a_sh;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] acc_sum;
  logic [DW-1:0]   b_sh;
  logic [CW-1:0]   cnt;

  // Accumulator value after the current iteration; product takes this
  // directly on the final step so the last partial product is included.
  always_comb begin
    acc_sum = acc;
    if (b_sh[0]) begin
      acc_sum = acc + a_sh;
    end
  end

  always_comb begin
    cnt_last = (cnt == CW'(DW - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= {{DW{1'b0}}, multiplicand};
      b_sh <= multiplier;
      acc  <= '0;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_sum;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
    end else if (store) begin
      product <= acc_sum;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential unsigned multiplier controller: captures operands on a start
// pulse, runs DW shift-add iterations, then presents the product for one
// DONE cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : single-cycle start pulse (ignored unless IDLE)
//   multiplicand  : operand A (DW bits)
//   multiplier    : operand B (DW bits)
//   product       : registered A*B, held until the next DONE
//   busy          : high in CALC and DONE
//   ready         : high only in DONE
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   multiplicand,
  input  logic [DW-1:0]   multiplier,
  output logic [2*DW-1:0] product,
  output logic            busy,
  output logic            ready
);

  mult_sequencer_state_e state, state_next;

  logic load;
  logic step;
  logic store;
  logic cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    store      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_last) begin
          store      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy  = (state == CALC) || (state == DONE);
    ready = (state == DONE);
  end

  mult_datapath #(
    .DW(DW)
  ) u_datapath (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .step         (step),
    .store        (store),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .cnt_last     (cnt_last)
  );

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8: operand width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: single-cycle start pulse, the debouncer one_shot output, already synchronous to clk.
REQ-005 SHALL have port multiplicand, input, DW bits: unsigned operand A.
REQ-006 SHALL have port multiplier, input, DW bits: unsigned operand B.
REQ-007 SHALL have port product, output, 2*DW bits: registered result of A*B.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-009 SHALL have port ready, output, 1 bit: one-cycle pulse marking the cycle product becomes valid.

Function
REQ-010 SHALL implement the states IDLE, CALC and DONE.
REQ-011 SHALL, in IDLE with start=1 at edge k, capture multiplicand and multiplier into internal registers at edge k, clear the accumulator and iteration counter, and enter CALC.
REQ-012 SHALL, in CALC on each edge, add the shifted multiplicand to the accumulator when multiplier bit 0 is 1, shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-013 SHALL leave CALC for DONE on the edge where the counter reaches DW-1, so CALC lasts exactly DW cycles.
REQ-014 SHALL write the final accumulator value into product on entry to DONE, and SHALL return from DONE to IDLE on the next edge.
REQ-015 SHALL drive ready=1 only while in DONE, giving exactly DW+1 cycles of latency from the start edge to ready high.
REQ-016 SHALL drive busy=1 in CALC and DONE, and busy=0 in IDLE.
REQ-017 SHALL hold product stable from DONE until the next DONE, including through later IDLE and CALC cycles.
REQ-018 SHALL ignore start while in CALC or DONE: no restart, no operand recapture, no queued request.
REQ-019 SHALL ignore operand input changes after the capture edge.
REQ-020 SHALL size the accumulator at 2*DW bits so the result never wraps; the maximum is (2^DW-1)^2.
REQ-021 SHALL produce product 0 when either operand is 0, with unchanged latency (no early exit).
REQ-022 SHALL accept a start arriving in the first IDLE cycle after DONE, allowing back-to-back operations.

Reset
REQ-023 SHALL, on rst=1 at any time including mid-CALC, immediately force state to IDLE, product to 0, busy to 0, ready to 0, and clear the counter and internal registers.
REQ-024 SHALL discard an in-flight operation on reset, and SHALL accept the first start on the first edge after rst falls.

Structure
REQ-025 SHALL place the state enum (mult_sequencer_state_e: IDLE, CALC, DONE) and the default width constant in shared package mult_sequencer_pkg.
REQ-026 SHALL place the shift-add datapath (operand shift registers, accumulator, counter) in sub-module mult_datapath, with the FSM in mult_sequencer.
REQ-027 SHALL implement the next-state logic and output decode as combinational blocks, and the state register as a separate asynchronous-reset sequential block.

Verification (DW=8)
REQ-028 SHALL verify basic multiply: A=13, B=11, start pulse -> ready high exactly 9 cycles later, product=143, busy high for 9 cycles.
REQ-029 SHALL verify boundary results: A=255, B=255 -> product=65025; A=0, B=200 -> product=0 with 9-cycle latency.
REQ-030 SHALL verify start during busy: start, then a second start 3 cycles later with A=2, B=2 -> single ready, product equals the first operation's result.
REQ-031 SHALL verify reset mid-operation: rst asserted in the 5th CALC cycle -> busy=0, product=0 and no ready; a new start with A=7, B=6 -> product=42.
REQ-032 SHALL verify back-to-back operation: start at the first IDLE cycle after ready, A=3, B=5 -> product=15; product holds the prior value until this DONE.
